// File: rtl/mdio_pkg.sv
// Clause-22 MDIO frame constants and receiver state encoding.
// Shared between the frame generator and the management target.
package mdio_pkg;

    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    // Bit indices within the 32-bit frame, MSB (start bit) is index 0
    localparam logic [4:0] IDX_OP_END   = 5'd3;
    localparam logic [4:0] IDX_REG_END  = 5'd13;
    localparam logic [4:0] IDX_TA_START = 5'd14;
    localparam logic [4:0] IDX_TA_END   = 5'd15;
    localparam logic [4:0] IDX_LAST     = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_TA,
        S_RDAT,
        S_WDAT,
        S_SKIP
    } mdio_state_e;

    function automatic logic op_valid(input logic [1:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/mdio_receptor_if.sv
// Serial MDIO lines plus the 32x16 register port of the management target.
// slave = the receptor, master = generator and register file side.
interface mdio_receptor_if;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic [15:0] MEM_RD_DATA;
    logic        MDIO_IN;
    logic        MDIO_IN_OE;
    logic [4:0]  MEM_ADDR;
    logic [15:0] MEM_WR_DATA;
    logic        MEM_WR;
    logic        MEM_RD;
    logic        BUSY;
    logic        FRAME_ERR;

    modport slave (
        input  MDC, MDIO_OUT, MDIO_OE, MEM_RD_DATA,
        output MDIO_IN, MDIO_IN_OE, MEM_ADDR, MEM_WR_DATA, MEM_WR, MEM_RD, BUSY, FRAME_ERR
    );

    modport master (
        output MDC, MDIO_OUT, MDIO_OE, MEM_RD_DATA,
        input  MDIO_IN, MDIO_IN_OE, MEM_ADDR, MEM_WR_DATA, MEM_WR, MEM_RD, BUSY, FRAME_ERR
    );
endinterface

// File: rtl/mdio_receptor_mdc_edge_det.sv
// Registers MDC in the clk domain and flags its rising edge for one clk.
// Only the rising edge is consumed by the frame logic, so no fall output is provided.
module mdc_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic mdc,
    output logic rise
);
    logic mdc_q;
    logic mdc_d;

    always_comb mdc_d = mdc;

    always_ff @(posedge clk) begin
        if (rst) mdc_q <= 1'b0;
        else     mdc_q <= mdc_d;
    end

    assign rise = mdc & ~mdc_q;
endmodule

// File: rtl/mdio_receptor.sv
// Clause-22 MDIO management target: decodes frames sampled on MDC rises, drives a
// 32x16 register port and returns read data serially on MDIO_IN.
module mdio_receptor
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter bit         BCAST_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    mdio_receptor_if.slave bus
);
    logic        mdc_rise;
    mdio_state_e state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [13:0] hdr_q, hdr_d;
    logic        is_read_q, is_read_d;
    logic [15:0] wr_sh_q, wr_sh_d;
    logic [15:0] tx_q, tx_d;
    logic        rd_dly_q;
    logic        mdio_in_q, mdio_in_d;
    logic        mdio_in_oe_q, mdio_in_oe_d;
    logic [4:0]  mem_addr_q, mem_addr_d;
    logic [15:0] mem_wr_data_q, mem_wr_data_d;
    logic        mem_wr_q, mem_wr_d;
    logic        mem_rd_q, mem_rd_d;
    logic        frame_err_q, frame_err_d;

    logic [13:0] hdr_shift;
    logic [1:0]  hdr_op;
    logic [4:0]  hdr_phy;
    logic        addr_ok;

    mdc_edge_det u_mdc_edge_det (
        .clk  (clk),
        .rst  (rst),
        .mdc  (bus.MDC),
        .rise (mdc_rise)
    );

    // hdr_shift[13] is frame bit 0, so fields sit at fixed offsets once bit 13 is in
    assign hdr_shift = {hdr_q[12:0], bus.MDIO_OUT};
    assign hdr_op    = hdr_shift[11:10];
    assign hdr_phy   = hdr_shift[9:5];
    // Broadcast address is honoured for writes only
    assign addr_ok   = (hdr_phy == PHY_ADDR) ||
                       (BCAST_EN && (hdr_phy == 5'd0) && (hdr_op == OP_WRITE));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hdr_d         = hdr_q;
        is_read_d     = is_read_q;
        wr_sh_d       = wr_sh_q;
        tx_d          = rd_dly_q ? bus.MEM_RD_DATA : tx_q;
        mdio_in_d     = mdio_in_q;
        mdio_in_oe_d  = mdio_in_oe_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        mem_wr_d      = 1'b0;
        mem_rd_d      = 1'b0;
        frame_err_d   = 1'b0;

        if (mdc_rise) begin
            cnt_d = cnt_q + 5'd1;
            unique case (state_q)
                S_IDLE: begin
                    cnt_d = cnt_q;
                    if (bus.MDIO_OE && !bus.MDIO_OUT) begin
                        state_d = S_HDR;
                        hdr_d   = hdr_shift;
                        cnt_d   = 5'd1;
                    end
                end
                S_HDR: begin
                    hdr_d = hdr_shift;
                    if (cnt_q == IDX_OP_END &&
                        (hdr_shift[3:2] != ST_START || !op_valid(hdr_shift[1:0]))) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                        cnt_d       = 5'd0;
                    end else if (cnt_q == IDX_REG_END) begin
                        is_read_d = (hdr_op == OP_READ);
                        if (addr_ok) begin
                            mem_addr_d = hdr_shift[4:0];
                            mem_rd_d   = (hdr_op == OP_READ);
                            state_d    = S_TA;
                        end else begin
                            state_d = S_SKIP;
                        end
                    end
                end
                S_TA: begin
                    if (!is_read_q && !bus.MDIO_OE) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                        cnt_d       = 5'd0;
                    end else begin
                        if (is_read_q) begin
                            // Drive 0 for the second turnaround bit, then present the MSB
                            mdio_in_oe_d = 1'b1;
                            mdio_in_d    = (cnt_q == IDX_TA_END) ? tx_q[15] : 1'b0;
                            if (cnt_q == IDX_TA_END) tx_d = {tx_q[14:0], 1'b0};
                        end
                        if (cnt_q == IDX_TA_END) state_d = is_read_q ? S_RDAT : S_WDAT;
                    end
                end
                S_RDAT: begin
                    if (cnt_q == IDX_LAST) begin
                        mdio_in_oe_d = 1'b0;
                        mdio_in_d    = 1'b0;
                        state_d      = S_IDLE;
                        cnt_d        = 5'd0;
                    end else begin
                        mdio_in_d = tx_q[15];
                        tx_d      = {tx_q[14:0], 1'b0};
                    end
                end
                S_WDAT: begin
                    if (!bus.MDIO_OE) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                        cnt_d       = 5'd0;
                    end else begin
                        wr_sh_d = {wr_sh_q[14:0], bus.MDIO_OUT};
                        if (cnt_q == IDX_LAST) begin
                            mem_wr_data_d = wr_sh_d;
                            mem_wr_d      = 1'b1;
                            state_d       = S_IDLE;
                            cnt_d         = 5'd0;
                        end
                    end
                end
                S_SKIP: begin
                    if (cnt_q == IDX_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = 5'd0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 5'd0;
            hdr_q         <= 14'd0;
            is_read_q     <= 1'b0;
            wr_sh_q       <= 16'd0;
            tx_q          <= 16'd0;
            rd_dly_q      <= 1'b0;
            mdio_in_q     <= 1'b0;
            mdio_in_oe_q  <= 1'b0;
            mem_addr_q    <= 5'd0;
            mem_wr_data_q <= 16'd0;
            mem_wr_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hdr_q         <= hdr_d;
            is_read_q     <= is_read_d;
            wr_sh_q       <= wr_sh_d;
            tx_q          <= tx_d;
            rd_dly_q      <= mem_rd_q;
            mdio_in_q     <= mdio_in_d;
            mdio_in_oe_q  <= mdio_in_oe_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_wr_q      <= mem_wr_d;
            mem_rd_q      <= mem_rd_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign bus.MDIO_IN     = mdio_in_q;
    assign bus.MDIO_IN_OE  = mdio_in_oe_q;
    assign bus.MEM_ADDR    = mem_addr_q;
    assign bus.MEM_WR_DATA = mem_wr_data_q;
    assign bus.MEM_WR      = mem_wr_q;
    assign bus.MEM_RD      = mem_rd_q;
    assign bus.BUSY        = (state_q != S_IDLE);
    assign bus.FRAME_ERR   = frame_err_q;
endmodule

// File: tb/tb_mdio_receptor.sv
// Directed and randomized MDIO frames against a field-level model of the target,
// with a register-file responder that only presents read data in its valid clk.
module tb_mdio_receptor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdio_receptor_if bus ();

    mdio_receptor #(.PHY_ADDR(5'd1), .BCAST_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] tb_mem  [32] = '{default: 16'h0};
    logic [15:0] ref_mem [32] = '{default: 16'h0};

    int          wr_cycles = 0, rd_cycles = 0, err_cycles = 0, both_cycles = 0;
    logic [4:0]  last_wr_addr, last_rd_addr, rd_addr_s;
    logic [15:0] last_wr_data;
    bit          rd_seen = 0, rd_hold = 0;

    logic [15:0] rx_word;
    logic        oe14_s, oe15_s, oe_all, oe_any;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Register file: read data valid only during the clk after MEM_RD
    always @(negedge clk) begin
        if (rd_hold) begin
            bus.MEM_RD_DATA = 16'($urandom);
            rd_hold = 0;
        end
        if (rd_seen) begin
            bus.MEM_RD_DATA = tb_mem[rd_addr_s];
            rd_seen = 0;
            rd_hold = 1;
        end
        if (bus.MEM_RD === 1'b1) begin
            rd_cycles++;
            rd_seen      = 1;
            rd_addr_s    = bus.MEM_ADDR;
            last_rd_addr = bus.MEM_ADDR;
        end
        if (bus.MEM_WR === 1'b1) begin
            wr_cycles++;
            last_wr_addr = bus.MEM_ADDR;
            last_wr_data = bus.MEM_WR_DATA;
            tb_mem[bus.MEM_ADDR] = bus.MEM_WR_DATA;
        end
        if (bus.FRAME_ERR === 1'b1) err_cycles++;
        if (bus.MEM_WR === 1'b1 && bus.MEM_RD === 1'b1) both_cycles++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mdc_pulse();
        bus.MDC = 1'b1;
        tick($urandom_range(1, 3));
        bus.MDC = 1'b0;
        tick($urandom_range(1, 3));
    endtask

    task automatic preamble();
        int n = $urandom_range(2, 6);
        for (int i = 0; i < n; i++) begin
            bus.MDIO_OUT = 1'b1;
            bus.MDIO_OE  = 1'b1;
            mdc_pulse();
        end
    endtask

    function automatic logic [31:0] mk(input logic [1:0] op, input logic [4:0] phy,
                                       input logic [4:0] ra, input logic [15:0] data);
        return {2'b01, op, phy, ra, 2'b10, data};
    endfunction

    // Drives the first nbits of a frame; the generator releases the line from bit 14 on reads
    task automatic send_frame(input logic [31:0] frame, input bit rd, input int nbits, input int drop_bit);
        oe_all = 1'b1;
        oe_any = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == 14) oe14_s = bus.MDIO_IN_OE;
            if (i == 15) oe15_s = bus.MDIO_IN_OE;
            if (i >= 16) begin
                rx_word[31-i] = bus.MDIO_IN;
                oe_all = oe_all & bus.MDIO_IN_OE;
                oe_any = oe_any | bus.MDIO_IN_OE;
            end
            bus.MDIO_OUT = frame[31-i];
            bus.MDIO_OE  = (rd && i >= 14) ? 1'b0 : ((i == drop_bit) ? 1'b0 : 1'b1);
            mdc_pulse();
        end
        bus.MDIO_OUT = 1'b0;
        bus.MDIO_OE  = 1'b0;
    endtask

    task automatic run_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                             input logic [15:0] data, input int drop_bit, input string tag);
        int wr0 = wr_cycles;
        int rd0 = rd_cycles;
        int er0 = err_cycles;
        bit addressed = (phy == 5'd1) || (phy == 5'd0 && op == 2'b01);
        bit acc_wr    = (op == 2'b01) && addressed && (drop_bit < 0);
        bit acc_rd    = (op == 2'b10) && addressed;
        bit exp_err   = (op == 2'b01) && addressed && (drop_bit >= 0);
        preamble();
        send_frame(mk(op, phy, ra, data), op == 2'b10, (drop_bit >= 0) ? drop_bit + 1 : 32, drop_bit);
        tick(4);
        chk({tag, " wr_count"}, wr_cycles - wr0, {31'd0, acc_wr});
        chk({tag, " rd_count"}, rd_cycles - rd0, {31'd0, acc_rd});
        chk({tag, " err_count"}, err_cycles - er0, {31'd0, exp_err});
        chk({tag, " busy_idle"}, {31'd0, bus.BUSY}, 32'd0);
        chk({tag, " in_oe_idle"}, {31'd0, bus.MDIO_IN_OE}, 32'd0);
        if (acc_wr) begin
            chk({tag, " wr_addr"}, {27'd0, last_wr_addr}, {27'd0, ra});
            chk({tag, " wr_data"}, {16'd0, last_wr_data}, {16'd0, data});
            ref_mem[ra] = data;
        end
        if (acc_rd) begin
            chk({tag, " rd_addr"}, {27'd0, last_rd_addr}, {27'd0, ra});
            chk({tag, " rd_data"}, {16'd0, rx_word}, {16'd0, ref_mem[ra]});
            chk({tag, " oe_ta14"}, {31'd0, oe14_s}, 32'd0);
            chk({tag, " oe_ta15"}, {31'd0, oe15_s}, 32'd1);
            chk({tag, " oe_data"}, {31'd0, oe_all}, 32'd1);
        end
        if (op == 2'b10 && !acc_rd) chk({tag, " oe_never"}, {31'd0, oe_any}, 32'd0);
        $display("frame %s op=%0b phy=%0d reg=%0d data=%h drop=%0d", tag, op, phy, ra, data, drop_bit);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " busy"}, {31'd0, bus.BUSY}, 32'd0);
        chk({tag, " mdio_in"}, {31'd0, bus.MDIO_IN}, 32'd0);
        chk({tag, " mdio_in_oe"}, {31'd0, bus.MDIO_IN_OE}, 32'd0);
        chk({tag, " mem_wr"}, {31'd0, bus.MEM_WR}, 32'd0);
        chk({tag, " mem_rd"}, {31'd0, bus.MEM_RD}, 32'd0);
        chk({tag, " frame_err"}, {31'd0, bus.FRAME_ERR}, 32'd0);
        chk({tag, " mem_addr"}, {27'd0, bus.MEM_ADDR}, 32'd0);
        chk({tag, " mem_wr_data"}, {16'd0, bus.MEM_WR_DATA}, 32'd0);
    endtask

    initial begin
        int wr0, rd0, er0;
        logic [1:0]  r_op;
        logic [4:0]  r_phy, r_reg;
        logic [15:0] r_data;
        int          r_drop;

        rst = 1'b1;
        bus.MDC = 1'b0;
        bus.MDIO_OUT = 1'b0;
        bus.MDIO_OE = 1'b0;
        tick(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        tick(2);

        run_frame(2'b01, 5'd1, 5'd3, 16'hBEEF, -1, "wr_beef");
        run_frame(2'b01, 5'd1, 5'd3, 16'h1234, -1, "wr_1234");
        run_frame(2'b10, 5'd1, 5'd3, 16'h0000, -1, "rd_1234");
        chk("rd_1234 literal", {16'd0, rx_word}, 32'h0000_1234);
        run_frame(2'b01, 5'd2, 5'd5, 16'hA5A5, -1, "wr_phy2");
        run_frame(2'b01, 5'd1, 5'd7, 16'h0F0F, -1, "wr_after_skip");

        // Malformed headers: only the first four bits are sent
        wr0 = wr_cycles; rd0 = rd_cycles; er0 = err_cycles;
        preamble();
        send_frame({2'b00, 2'b01, 28'h0}, 1'b0, 4, -1);
        tick(4);
        chk("st00 err", err_cycles - er0, 32'd1);
        chk("st00 busy", {31'd0, bus.BUSY}, 32'd0);
        preamble();
        send_frame({2'b01, 2'b11, 28'h0}, 1'b0, 4, -1);
        tick(4);
        chk("op11 err", err_cycles - er0, 32'd2);
        chk("op11 busy", {31'd0, bus.BUSY}, 32'd0);
        chk("bad_hdr strobes", (wr_cycles - wr0) + (rd_cycles - rd0), 32'd0);
        $display("frame bad_hdr st=00 then op=11");

        // Reset through bit 20 of a write
        wr0 = wr_cycles;
        preamble();
        send_frame(mk(2'b01, 5'd1, 5'd9, 16'h7777), 1'b0, 21, -1);
        chk("pre_rst busy", {31'd0, bus.BUSY}, 32'd1);
        rst = 1'b1;
        tick(1);
        check_outputs_zero("mid_rst");
        rst = 1'b0;
        tick(2);
        chk("mid_rst no_wr", wr_cycles - wr0, 32'd0);
        $display("frame mid_rst reg=9 aborted at bit 20");
        run_frame(2'b01, 5'd1, 5'd3, 16'hBEEF, -1, "wr_beef_again");

        run_frame(2'b01, 5'd0, 5'd4, 16'hC0DE, -1, "bcast_wr");
        run_frame(2'b10, 5'd0, 5'd4, 16'h0000, -1, "bcast_rd");
        run_frame(2'b10, 5'd1, 5'd4, 16'h0000, -1, "rd_bcast_reg");

        for (int n = 0; n < 24; n++) begin
            r_op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            case ($urandom_range(0, 3))
                0:       r_phy = 5'd0;
                1, 2:    r_phy = 5'd1;
                default: r_phy = 5'($urandom_range(2, 31));
            endcase
            r_reg  = 5'($urandom);
            r_data = 16'($urandom);
            r_drop = -1;
            if (r_op == 2'b01 && r_phy <= 5'd1 && $urandom_range(0, 4) == 0)
                r_drop = $urandom_range(16, 31);
            run_frame(r_op, r_phy, r_reg, r_data, r_drop, $sformatf("rand%0d", n));
        end

        chk("wr_rd_overlap", both_cycles, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
